// File: rtl/sail_bus_defs.sv
// Shared definitions for the data-memory bus fabric: FSM encodings,
// target select codes and the default RAM/MMIO address boundary.
package sail_bus_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic TGT_RAM  = 1'b0;
  localparam logic TGT_MMIO = 1'b1;

  localparam logic [31:0] DEFAULT_SPLIT_ADDR = 32'h0002_0000;

endpackage

// File: rtl/mux2to1.sv
// Generic two-input data select; used on the response return path.
module mux2to1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? a1_i : a0_i;

endmodule

// File: rtl/bus_demux1to2.sv
// Registered 1-to-2 request router (RAM / MMIO), one transaction in flight.
// Optional response timeout enabled by defining DEMUX_TIMEOUT_EN.
module bus_demux1to2
  import sail_bus_defs::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SPLIT_ADDR = ADDR_WIDTH'(DEFAULT_SPLIT_ADDR),
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [3:0]            req_wstrb,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  t0_valid,
  input  logic                  t0_ready,
  output logic [ADDR_WIDTH-1:0] t0_addr,
  output logic                  t0_we,
  output logic [3:0]            t0_wstrb,
  output logic [DATA_WIDTH-1:0] t0_wdata,
  input  logic                  t0_rsp_valid,
  input  logic [DATA_WIDTH-1:0] t0_rsp_rdata,
  output logic                  t1_valid,
  input  logic                  t1_ready,
  output logic [ADDR_WIDTH-1:0] t1_addr,
  output logic                  t1_we,
  output logic [3:0]            t1_wstrb,
  output logic [DATA_WIDTH-1:0] t1_wdata,
  input  logic                  t1_rsp_valid,
  input  logic [DATA_WIDTH-1:0] t1_rsp_rdata
);

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  tgt_ready, tgt_rsp_valid;
  logic [DATA_WIDTH-1:0] tgt_rdata;

`ifdef DEMUX_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  mux2to1 #(.WIDTH(DATA_WIDTH)) u_rsp_mux (
    .sel_i (sel_q),
    .a0_i  (t0_rsp_rdata),
    .a1_i  (t1_rsp_rdata),
    .y_o   (tgt_rdata)
  );

  // Only the selected target's handshake and response are ever observed.
  assign tgt_ready     = (sel_q == TGT_MMIO) ? t1_ready     : t0_ready;
  assign tgt_rsp_valid = (sel_q == TGT_MMIO) ? t1_rsp_valid : t0_rsp_valid;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef DEMUX_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          sel_d   = (req_addr >= SPLIT_ADDR) ? TGT_MMIO : TGT_RAM;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tgt_ready) begin
          state_d = WAIT;
`ifdef DEMUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (tgt_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : tgt_rdata;
          state_d     = IDLE;
        end
`ifdef DEMUX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= TGT_RAM;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef DEMUX_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  // Request fields fan out to both targets; only valid is steered.
  assign t0_valid = (state_q == ISSUE) && (sel_q == TGT_RAM);
  assign t1_valid = (state_q == ISSUE) && (sel_q == TGT_MMIO);
  assign t0_addr  = addr_q;
  assign t0_we    = we_q;
  assign t0_wstrb = wstrb_q;
  assign t0_wdata = wdata_q;
  assign t1_addr  = addr_q;
  assign t1_we    = we_q;
  assign t1_wstrb = wstrb_q;
  assign t1_wdata = wdata_q;

endmodule
